// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, state encoding and coefficient map for the conv MAC layers
package conv_pkg;
    localparam int KERNEL_SIZE = 4;
    localparam logic [2:0] W_ADDR_BIAS = 3'd4;
    typedef enum logic [1:0] {IDLE, MAC, ROUND, HOLD} mac_state_t;
endpackage

// File: rtl/dilated_tap_mac_if.sv
// dilated_tap_mac_if: window input, coefficient write port and result output of one MAC channel
interface dilated_tap_mac_if
    import conv_pkg::*;
#(parameter int W = 16);
    logic                in_valid, in_ready, w_we, out_valid, out_ready;
    logic signed [W-1:0] taps [KERNEL_SIZE];
    logic signed [W-1:0] w_data, out;
    logic [2:0]          w_addr;
    modport master(output in_valid, taps, w_we, w_addr, w_data, out_ready,
                   input in_ready, out_valid, out);
    modport slave(input in_valid, taps, w_we, w_addr, w_data, out_ready,
                  output in_ready, out_valid, out);
endinterface

// File: rtl/round_saturate.sv
// round_saturate: fixed-point round half toward +inf, then clamp to a signed W-bit result
module round_saturate #(
    parameter int ACC_W = 35,
    parameter int W     = 16,
    parameter int FRAC  = 8
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [W-1:0]     out
);
    // (2**FRAC)/2 collapses to zero when FRAC=0, so no rounding add in that case
    localparam logic signed [ACC_W-1:0] RND  = ACC_W'((2**FRAC) / 2);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2**(W-1) - 1);
    localparam logic signed [ACC_W-1:0] MINV = -MAXV - 1;
    logic signed [ACC_W-1:0] r;
    always_comb begin
        r = (acc + RND) >>> FRAC;
        out = r > MAXV ? MAXV[W-1:0] : r < MINV ? MINV[W-1:0] : r[W-1:0];
    end
endmodule

// File: rtl/dilated_tap_mac.sv
// dilated_tap_mac: serial 4-tap MAC with bias, rounding and saturation, valid/ready on both sides
module dilated_tap_mac
    import conv_pkg::*;
#(
    parameter int W     = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 2*W+3
) (
    input logic clk,
    input logic rst,
    dilated_tap_mac_if.slave bus
);
    mac_state_t                state, state_d;
    logic signed [W-1:0]       coef [KERNEL_SIZE+1];
    logic signed [W-1:0]       tap_q [KERNEL_SIZE];
    logic signed [W-1:0]       w_q [KERNEL_SIZE];
    logic signed [ACC_W-1:0]   acc, bias_ext;
    logic signed [2*W-1:0]     prod;
    logic signed [W-1:0]       rs_out, out_q;
    logic [1:0]                k;
    logic                      out_valid_q, accept;

    assign accept   = bus.in_valid && state == IDLE;
    assign bias_ext = ACC_W'(coef[W_ADDR_BIAS]) <<< FRAC;
    assign prod     = tap_q[k] * w_q[k];

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;

    round_saturate #(.ACC_W(ACC_W), .W(W), .FRAC(FRAC)) u_rs (.acc(acc), .out(rs_out));

    always_comb begin
        state_d = state;
        state_d = state == IDLE  ? (bus.in_valid ? MAC : IDLE) :
                  state == MAC   ? (k == 2'(KERNEL_SIZE-1) ? ROUND : MAC) :
                  state == ROUND ? HOLD :
                  (bus.out_ready ? IDLE : HOLD);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_d;

    // coefficients are read before this edge's write lands, so a write on the accept edge misses this window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coef        <= '{default: '0};
            tap_q       <= '{default: '0};
            w_q         <= '{default: '0};
            acc         <= '0;
            k           <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (bus.w_we && bus.w_addr <= W_ADDR_BIAS) coef[bus.w_addr] <= bus.w_data;
            if (accept) begin
                tap_q <= bus.taps;
                for (int i = 0; i < KERNEL_SIZE; i++) w_q[i] <= coef[i];
                acc <= bias_ext;
                k   <= '0;
            end
            if (state == MAC) begin
                acc <= acc + ACC_W'(prod);
                k   <= k + 2'd1;
            end
            if (state == ROUND) begin
                out_q       <= rs_out;
                out_valid_q <= 1'b1;
            end
            if (state == HOLD && bus.out_ready) out_valid_q <= 1'b0;
        end
    end
endmodule
